// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and forwarding controller for the 5-stage RISC-V pipeline.
//   Resolves load-use hazards and taken-branch redirects, selects operand
//   forwarding for EX, and holds the pipeline while an iterative MUL/DIV
//   occupies EX. Two saturating perf counters track stall cycles and taken
//   redirects.
//
// State table (multicycle EX FSM)
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no multicycle op in flight; start in EX begins the stall
//   ST_BUSY | op iterating; stall while mc_cnt!=0, done pulse at mc_cnt==0
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_rs1_addr_d, i_rs2_addr_d   source registers of the DECODE instruction
//   i_rs1_addr_e, i_rs2_addr_e   source registers of the EX instruction
//   i_rd_addr_e, i_regwrite_e    EX destination and write enable
//   i_load_e, i_mc_start_e       EX is a load / a multicycle op
//   i_rd_addr_m, i_regwrite_m    MEM destination and write enable
//   i_rd_addr_w, i_regwrite_w    WB destination and write enable
//   i_pcsrc_e                    taken branch/jump resolved in EX
//   i_cnt_clr                    clear both perf counters
//   o_stall_f/d/e                hold PC / IF-ID / ID-EX
//   o_flush_d/e/m                bubble into IF-ID / ID-EX / EX-MEM
//   o_forward_a_e/b_e            00 regfile, 10 MEM result, 01 WB result
//   o_mc_busy, o_mc_done         FSM busy / one-cycle result-valid pulse
//   o_stall_cnt, o_flush_cnt     saturating perf counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int P_REG_ADDR_WIDTH = 5,
  parameter int P_MC_LAT         = 4,
  parameter int P_CNT_WIDTH      = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [P_REG_ADDR_WIDTH-1:0] i_rs1_addr_d,
  input  logic [P_REG_ADDR_WIDTH-1:0] i_rs2_addr_d,
  input  logic [P_REG_ADDR_WIDTH-1:0] i_rs1_addr_e,
  input  logic [P_REG_ADDR_WIDTH-1:0] i_rs2_addr_e,
  input  logic [P_REG_ADDR_WIDTH-1:0] i_rd_addr_e,
  input  logic                        i_regwrite_e,
  input  logic                        i_load_e,
  input  logic                        i_mc_start_e,
  input  logic [P_REG_ADDR_WIDTH-1:0] i_rd_addr_m,
  input  logic                        i_regwrite_m,
  input  logic [P_REG_ADDR_WIDTH-1:0] i_rd_addr_w,
  input  logic                        i_regwrite_w,
  input  logic                        i_pcsrc_e,
  input  logic                        i_cnt_clr,
  output logic                        o_stall_f,
  output logic                        o_stall_d,
  output logic                        o_stall_e,
  output logic                        o_flush_d,
  output logic                        o_flush_e,
  output logic                        o_flush_m,
  output logic [1:0]                  o_forward_a_e,
  output logic [1:0]                  o_forward_b_e,
  output logic                        o_mc_busy,
  output logic                        o_mc_done,
  output logic [P_CNT_WIDTH-1:0]      o_stall_cnt,
  output logic [P_CNT_WIDTH-1:0]      o_flush_cnt
);

  if (P_MC_LAT < 2) begin : g_bad_mc_lat
    $error("pipe_hazard_ctrl: P_MC_LAT must be >= 2");
  end

  // Down-counter only needs to hold P_MC_LAT-2.
  localparam int                  MC_CNT_W = (P_MC_LAT > 2) ? $clog2(P_MC_LAT) : 1;
  localparam logic [MC_CNT_W-1:0] MC_LOAD  = MC_CNT_W'(P_MC_LAT - 2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mc_state_t;

  mc_state_t             mc_state;
  logic [MC_CNT_W-1:0]   mc_cnt;

  logic                  mc_stall;
  logic                  mc_done;
  logic                  load_use;
  logic                  redirect;

  // EX write enable is not needed: only loads create a decode-side hazard,
  // ALU results reach EX through the MEM/WB forwarding paths.
  logic                  unused_regwrite_e;
  assign unused_regwrite_e = i_regwrite_e;

  // -------------------------------------------------------------------------
  // Multicycle EX FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mc_state <= ST_IDLE;
      mc_cnt   <= '0;
    end else begin
      case (mc_state)
        ST_IDLE: begin
          if (i_mc_start_e) begin
            mc_state <= ST_BUSY;
            mc_cnt   <= MC_LOAD;
          end
        end
        ST_BUSY: begin
          // start is ignored here: the same instruction is still in EX
          if (mc_cnt == '0) begin
            mc_state <= ST_IDLE;
          end else begin
            mc_cnt <= mc_cnt - 1'b1;
          end
        end
        default: begin
          mc_state <= ST_IDLE;
          mc_cnt   <= '0;
        end
      endcase
    end
  end

  // The start cycle itself stalls, so total stall is P_MC_LAT-1 cycles and
  // EX advances on the done cycle.
  assign mc_stall = !i_rst &&
                    (((mc_state == ST_IDLE) && i_mc_start_e) ||
                     ((mc_state == ST_BUSY) && (mc_cnt != '0)));
  assign mc_done  = !i_rst && (mc_state == ST_BUSY) && (mc_cnt == '0);

  assign o_mc_busy = !i_rst && (mc_state == ST_BUSY);
  assign o_mc_done = mc_done;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  assign load_use = i_load_e && (i_rd_addr_e != '0) &&
                    ((i_rd_addr_e == i_rs1_addr_d) || (i_rd_addr_e == i_rs2_addr_d));

  // Priority: reset, multicycle stall, branch redirect, load-use.
  // A redirect squashes the younger instruction, so stalling it is pointless.
  always_comb begin
    o_stall_f = 1'b0;
    o_stall_d = 1'b0;
    o_stall_e = 1'b0;
    o_flush_d = 1'b0;
    o_flush_e = 1'b0;
    o_flush_m = 1'b0;
    if (i_rst) begin
      o_flush_d = 1'b1;
      o_flush_e = 1'b1;
      o_flush_m = 1'b1;
    end else if (mc_stall) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_stall_e = 1'b1;
      o_flush_m = 1'b1;
    end else if (i_pcsrc_e) begin
      o_flush_d = 1'b1;
      o_flush_e = 1'b1;
    end else if (load_use) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_flush_e = 1'b1;
    end
  end

  assign redirect = !i_rst && !mc_stall && i_pcsrc_e;

  // -------------------------------------------------------------------------
  // Forwarding: MEM beats WB (younger value), x0 never forwarded
  // -------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [P_REG_ADDR_WIDTH-1:0] rs,
    input logic [P_REG_ADDR_WIDTH-1:0] rd_m,
    input logic                        we_m,
    input logic [P_REG_ADDR_WIDTH-1:0] rd_w,
    input logic                        we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    o_forward_a_e = 2'b00;
    o_forward_b_e = 2'b00;
    if (!i_rst) begin
      o_forward_a_e = fwd_sel(i_rs1_addr_e, i_rd_addr_m, i_regwrite_m,
                              i_rd_addr_w, i_regwrite_w);
      o_forward_b_e = fwd_sel(i_rs2_addr_e, i_rd_addr_m, i_regwrite_m,
                              i_rd_addr_w, i_regwrite_w);
    end
  end

  // -------------------------------------------------------------------------
  // Saturating perf counters
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst || i_cnt_clr) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stall_f && (o_stall_cnt != '1)) begin
        o_stall_cnt <= o_stall_cnt + 1'b1;
      end
      if (redirect && (o_flush_cnt != '1)) begin
        o_flush_cnt <= o_flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_e, load_e, mc_start, regwrite_m, regwrite_w, pcsrc, cnt_clr;

  // dut_a: default parameters
  logic        a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_busy, a_done;
  logic [1:0]  a_fa, a_fb;
  logic [15:0] a_scnt, a_fcnt;
  // dut_b: P_MC_LAT=2, P_CNT_WIDTH=4
  logic        b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_busy, b_done;
  logic [1:0]  b_fa, b_fb;
  logic [3:0]  b_scnt, b_fcnt;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d),
    .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e),
    .i_rd_addr_e(rd_e), .i_regwrite_e(regwrite_e),
    .i_load_e(load_e), .i_mc_start_e(mc_start),
    .i_rd_addr_m(rd_m), .i_regwrite_m(regwrite_m),
    .i_rd_addr_w(rd_w), .i_regwrite_w(regwrite_w),
    .i_pcsrc_e(pcsrc), .i_cnt_clr(cnt_clr),
    .o_stall_f(a_sf), .o_stall_d(a_sd), .o_stall_e(a_se),
    .o_flush_d(a_fd), .o_flush_e(a_fe), .o_flush_m(a_fm),
    .o_forward_a_e(a_fa), .o_forward_b_e(a_fb),
    .o_mc_busy(a_busy), .o_mc_done(a_done),
    .o_stall_cnt(a_scnt), .o_flush_cnt(a_fcnt)
  );

  pipe_hazard_ctrl #(.P_REG_ADDR_WIDTH(5), .P_MC_LAT(2), .P_CNT_WIDTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_addr_d(rs1_d), .i_rs2_addr_d(rs2_d),
    .i_rs1_addr_e(rs1_e), .i_rs2_addr_e(rs2_e),
    .i_rd_addr_e(rd_e), .i_regwrite_e(regwrite_e),
    .i_load_e(load_e), .i_mc_start_e(mc_start),
    .i_rd_addr_m(rd_m), .i_regwrite_m(regwrite_m),
    .i_rd_addr_w(rd_w), .i_regwrite_w(regwrite_w),
    .i_pcsrc_e(pcsrc), .i_cnt_clr(cnt_clr),
    .o_stall_f(b_sf), .o_stall_d(b_sd), .o_stall_e(b_se),
    .o_flush_d(b_fd), .o_flush_e(b_fe), .o_flush_m(b_fm),
    .o_forward_a_e(b_fa), .o_forward_b_e(b_fb),
    .o_mc_busy(b_busy), .o_mc_done(b_done),
    .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, fwd_a, fwd_b}
  function automatic logic [31:0] outs_a();
    return {22'd0, a_sf, a_sd, a_se, a_fd, a_fe, a_fm, a_fa, a_fb};
  endfunction

  function automatic logic [31:0] outs_b();
    return {22'd0, b_sf, b_sd, b_se, b_fd, b_fe, b_fm, b_fa, b_fb};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    regwrite_e = 0; load_e = 0; mc_start = 0; regwrite_m = 0; regwrite_w = 0;
    pcsrc = 0; cnt_clr = 0;
  endtask

  task automatic set_lu();
    load_e = 1; regwrite_e = 1; rd_e = 5'd7; rs2_d = 5'd7;
  endtask

  typedef struct {
    string       name;
    int          rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    bit          regwrite_e, load_e;
    int          rd_m;
    bit          rw_m;
    int          rd_w;
    bit          rw_w, pcsrc;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // name          rs1d rs2d rs1e rs2e rde we ld  rdm wm rdw ww pc  exp{sf sd se fd fe fm fa fb}
    vecs[0]  = '{"fwd_mem",      0, 0, 5, 0, 0, 0, 0, 5, 1, 5, 1, 0, 32'b000000_10_00};
    vecs[1]  = '{"fwd_wb",       0, 0, 5, 0, 0, 0, 0, 5, 0, 5, 1, 0, 32'b000000_01_00};
    vecs[2]  = '{"fwd_x0",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 32'b000000_00_00};
    vecs[3]  = '{"fwd_split",    0, 0, 3, 9, 0, 0, 0, 3, 1, 9, 1, 0, 32'b000000_10_01};
    vecs[4]  = '{"fwd_none",     0, 0, 3, 9, 0, 0, 0, 3, 0, 9, 0, 0, 32'b000000_00_00};
    vecs[5]  = '{"lu_rs2",       0, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 32'b110010_00_00};
    vecs[6]  = '{"lu_rs1",       7, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 32'b110010_00_00};
    vecs[7]  = '{"lu_x0",        0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'b000000_00_00};
    vecs[8]  = '{"no_load",      7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 32'b000000_00_00};
    vecs[9]  = '{"branch",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'b000110_00_00};
    vecs[10] = '{"lu_branch",    0, 7, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, 32'b000110_00_00};
    vecs[11] = '{"fwd_both_mem", 0, 0, 4, 4, 0, 0, 0, 4, 1, 4, 1, 0, 32'b000000_10_10};

    // Reset with forwarding/branch/start inputs active: reset must win.
    set_idle();
    rst = 1;
    rd_m = 5'd5; regwrite_m = 1; rs1_e = 5'd5; pcsrc = 1; mc_start = 1;
    samp();
    check("rst_outs", outs_a(), 32'b000111_00_00);
    check("rst_done_busy", {30'd0, a_done, a_busy}, 32'd0);
    tick();
    samp();
    check("rst_cnts", {a_scnt, a_fcnt}, 32'd0);

    // Combinational vector table (FSM idle).
    tick();
    rst = 0;
    set_idle();
    for (int i = 0; i < 12; i++) begin
      rs1_d = 5'(vecs[i].rs1_d); rs2_d = 5'(vecs[i].rs2_d);
      rs1_e = 5'(vecs[i].rs1_e); rs2_e = 5'(vecs[i].rs2_e);
      rd_e = 5'(vecs[i].rd_e); regwrite_e = vecs[i].regwrite_e; load_e = vecs[i].load_e;
      rd_m = 5'(vecs[i].rd_m); regwrite_m = vecs[i].rw_m;
      rd_w = 5'(vecs[i].rd_w); regwrite_w = vecs[i].rw_w;
      pcsrc = vecs[i].pcsrc;
      samp();
      check(vecs[i].name, outs_a(), vecs[i].exp);
      tick();
    end

    // Counter clear, then a single load-use cycle.
    set_idle();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    set_lu();
    samp();
    check("clr_stall_cnt", 32'(a_scnt), 32'd0);
    check("clr_flush_cnt", 32'(a_fcnt), 32'd0);
    check("lu_outs", outs_a(), 32'b110010_00_00);
    tick();
    set_idle();
    samp();
    check("lu_released", outs_a(), 32'd0);
    check("lu_stall_cnt", 32'(a_scnt), 32'd1);

    // Load-use and branch together: branch wins, only flush_cnt moves.
    tick();
    set_lu();
    pcsrc = 1;
    samp();
    check("lu_br_outs", outs_a(), 32'b000110_00_00);
    tick();
    set_idle();
    samp();
    check("lu_br_stall_cnt", 32'(a_scnt), 32'd1);
    check("lu_br_flush_cnt", 32'(a_fcnt), 32'd1);

    // Multicycle op, P_MC_LAT=4, with a branch request held throughout.
    tick();
    mc_start = 1;
    pcsrc = 1;
    for (int c = 1; c <= 4; c++) begin
      samp();
      if (c <= 3) begin
        check($sformatf("mc_stall_c%0d", c), outs_a(), 32'b111001_00_00);
        check($sformatf("mc_done_busy_c%0d", c), {30'd0, a_done, a_busy},
              (c >= 2) ? 32'd1 : 32'd0);
      end else begin
        check("mc_done_outs", outs_a(), 32'b000110_00_00);
        check("mc_done_pulse", 32'(a_done), 32'd1);
      end
      tick();
    end
    set_idle();
    samp();
    check("mc_after_done_busy", {30'd0, a_done, a_busy}, 32'd0);
    check("mc_stall_cnt", 32'(a_scnt), 32'd4);
    check("mc_flush_cnt", 32'(a_fcnt), 32'd2);

    // Reset during the 2nd BUSY cycle aborts the op.
    tick();
    rst = 1; tick(); rst = 0;
    mc_start = 1;
    tick();
    tick();
    rst = 1;
    samp();
    check("mc_rst_outs", outs_a(), 32'b000111_00_00);
    check("mc_rst_done", 32'(a_done), 32'd0);
    tick();
    rst = 0;
    mc_start = 0;
    samp();
    check("mc_rst_idle", {30'd0, a_done, a_busy}, 32'd0);
    check("mc_rst_cnts", {a_scnt, a_fcnt}, 32'd0);
    tick();
    samp();
    check("mc_rst_no_late_done", {30'd0, a_done, a_busy}, 32'd0);

    // P_MC_LAT=2: exactly one stall cycle, then done.
    tick();
    mc_start = 1;
    samp();
    check("lat2_stall", outs_b(), 32'b111001_00_00);
    check("lat2_done_c1", 32'(b_done), 32'd0);
    tick();
    samp();
    check("lat2_done_outs", outs_b(), 32'd0);
    check("lat2_done_c2", 32'(b_done), 32'd1);
    tick();
    mc_start = 0;
    samp();
    check("lat2_stall_cnt", 32'(b_scnt), 32'd1);
    repeat (4) tick();

    // Saturation: 20 load-use stall cycles.
    rst = 1;
    tick();
    rst = 0;
    set_lu();
    repeat (19) tick();
    tick();
    set_idle();
    samp();
    check("sat_b_stall_cnt", 32'(b_scnt), 32'd15);
    check("sat_a_stall_cnt", 32'(a_scnt), 32'd20);
    tick();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    samp();
    check("sat_clr_b", 32'(b_scnt), 32'd0);
    check("sat_clr_a", 32'(a_scnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
